// File: rtl/clk_aux_pkg.sv
// Shared types and constants for the auxiliary 27 MHz clock sequencer.
// The led_state encoding is what the board shows on LEDR2/LEDR3.
package clk_aux_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ENABLING  = 3'd1,
    ACTIVE    = 3'd2,
    DISABLING = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // FAULT deliberately shares the DISABLING code; the fault output tells them apart.
  localparam logic [1:0] LED_IDLE      = 2'd0;
  localparam logic [1:0] LED_ENABLING  = 2'd1;
  localparam logic [1:0] LED_ACTIVE    = 2'd2;
  localparam logic [1:0] LED_DISABLING = 2'd3;
  localparam logic [1:0] LED_FAULT     = 2'd3;

  localparam int DEF_DEB_CYCLES    = 16;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_DRAIN_CYCLES  = 4;
  localparam int DEF_WDOG_CYCLES   = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_aux_ctrl_sw_debounce.sv
// Two-flop synchronizer plus stability counter for a bouncy board switch.
// A new level is accepted on the DEB_CYCLES-th consecutive edge it differs from db.
module sw_debounce
  import clk_aux_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic CLK,
  input  logic NRST,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  if (DEB_CYCLES <= 0) begin : g_bad_params
    $error("sw_debounce: DEB_CYCLES must be nonzero");
  end

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_aux_ctrl.sv
// Sequencer for the auxiliary clock: debounced request, settle/drain phases,
// and a heartbeat watchdog that latches a fault while the clock is selected.
module clk_aux_ctrl
  import clk_aux_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int WDOG_CYCLES   = DEF_WDOG_CYCLES
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       sw_req,
  input  logic       aux_toggle,
  output logic       sel_clk_aux,
  output logic       aux_ready,
  output logic       fault,
  output logic [1:0] led_state
);

  localparam int PMAX = max2(SETTLE_CYCLES, DRAIN_CYCLES);
  localparam int PW   = $clog2(PMAX + 1);
  localparam int WW   = $clog2(WDOG_CYCLES + 1);

  if (SETTLE_CYCLES <= 0 || DRAIN_CYCLES <= 0 || WDOG_CYCLES <= 0) begin : g_bad_params
    $error("clk_aux_ctrl: SETTLE_CYCLES, DRAIN_CYCLES and WDOG_CYCLES must be nonzero");
  end

  logic sw_db;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw_debounce (
    .CLK  (CLK),
    .NRST (NRST),
    .raw  (sw_req),
    .db   (sw_db)
  );

  // Heartbeat: any change of the synchronized toggle level is one beat.
  logic [1:0] tog_sync;
  logic       tog_prev;
  logic       hb;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      tog_sync <= '0;
      tog_prev <= 1'b0;
    end else begin
      tog_sync <= {tog_sync[0], aux_toggle};
      tog_prev <= tog_sync[1];
    end
  end

  assign hb = tog_sync[1] ^ tog_prev;

  state_t        state, state_next;
  logic [PW-1:0] phase;
  logic [WW-1:0] wdog;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state <= IDLE;
      phase <= '0;
      wdog  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        phase <= '0;
      end else if (phase < PW'(PMAX)) begin
        phase <= phase + PW'(1);
      end
      // Held at zero outside ACTIVE, so it is already clear on entry.
      if (state != ACTIVE || hb) begin
        wdog <= '0;
      end else if (wdog != WW'(WDOG_CYCLES)) begin
        wdog <= wdog + WW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sw_db) state_next = ENABLING;
      end
      ENABLING: begin
        if (!sw_db)                                state_next = DISABLING;
        else if (phase == PW'(SETTLE_CYCLES - 1)) state_next = ACTIVE;
      end
      ACTIVE: begin
        // A withdrawn request wins over a simultaneous watchdog expiry.
        if (!sw_db)                                   state_next = DISABLING;
        else if (!hb && wdog == WW'(WDOG_CYCLES))     state_next = FAULT;
      end
      DISABLING: begin
        if (phase == PW'(DRAIN_CYCLES - 1)) state_next = IDLE;
      end
      FAULT: begin
        if (!sw_db) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_clk_aux = 1'b0;
    aux_ready   = 1'b0;
    fault       = 1'b0;
    led_state   = LED_IDLE;
    case (state)
      ENABLING: begin
        sel_clk_aux = 1'b1;
        led_state   = LED_ENABLING;
      end
      ACTIVE: begin
        sel_clk_aux = 1'b1;
        aux_ready   = 1'b1;
        led_state   = LED_ACTIVE;
      end
      DISABLING: begin
        sel_clk_aux = 1'b1;
        led_state   = LED_DISABLING;
      end
      FAULT: begin
        fault     = 1'b1;
        led_state = LED_FAULT;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clk_aux_ctrl.sv
// Bench for clk_aux_ctrl: timestamp-based reference model compared every cycle,
// directed latency checks from the spec timeline, then randomized switch/heartbeat traffic.
module tb_clk_aux_ctrl;

  localparam int DEB    = 16;
  localparam int SETTLE = 8;
  localparam int DRAIN  = 4;
  localparam int WDOG   = 64;

  logic       CLK        = 1'b0;
  logic       NRST       = 1'b0;
  logic       sw_req     = 1'b0;
  logic       aux_toggle = 1'b0;
  logic       sel_clk_aux, aux_ready, fault;
  logic [1:0] led_state;
  logic       sel_b, ready_b, fault_b;
  logic [1:0] led_b;

  int n_cmp = 0;
  int n_err = 0;
  int tog_period = 0;
  int tog_cnt = 0;

  clk_aux_ctrl #(
    .DEB_CYCLES(DEB), .SETTLE_CYCLES(SETTLE), .DRAIN_CYCLES(DRAIN), .WDOG_CYCLES(WDOG)
  ) dut (
    .CLK(CLK), .NRST(NRST), .sw_req(sw_req), .aux_toggle(aux_toggle),
    .sel_clk_aux(sel_clk_aux), .aux_ready(aux_ready), .fault(fault), .led_state(led_state)
  );

  // Long settle so a release can land while still ENABLING.
  clk_aux_ctrl #(
    .DEB_CYCLES(DEB), .SETTLE_CYCLES(40), .DRAIN_CYCLES(DRAIN), .WDOG_CYCLES(WDOG)
  ) dut_b (
    .CLK(CLK), .NRST(NRST), .sw_req(sw_req), .aux_toggle(aux_toggle),
    .sel_clk_aux(sel_b), .aux_ready(ready_b), .fault(fault_b), .led_state(led_b)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_EN, M_ACT, M_DIS, M_FAULT} mstate_t;
  mstate_t m_state  = M_IDLE;
  int      m_edge   = 0;
  int      m_entry  = 0;
  int      m_wd_ref = 0;
  logic    m_db     = 1'b0;
  logic    m_hb     = 1'b0;
  logic    m_flip   = 1'b0;
  logic    sw_h[2]    = '{default: 1'b0};
  logic    tog_h[3]   = '{default: 1'b0};
  logic    sync_h[DEB] = '{default: 1'b0};

  initial begin
    forever begin
      @(posedge CLK or negedge NRST);
      if (!NRST) begin
        m_state = M_IDLE;
        m_db    = 1'b0;
        sw_h    = '{default: 1'b0};
        tog_h   = '{default: 1'b0};
        sync_h  = '{default: 1'b0};
      end else begin
        m_edge++;
        // Raw inputs reach the logic two edges after they are sampled.
        m_hb = (tog_h[1] != tog_h[2]);
        case (m_state)
          M_IDLE: if (m_db) begin m_state = M_EN; m_entry = m_edge; end
          M_EN: begin
            if (!m_db) begin
              m_state = M_DIS; m_entry = m_edge;
            end else if (m_edge - m_entry == SETTLE) begin
              m_state = M_ACT; m_entry = m_edge; m_wd_ref = m_edge;
            end
          end
          M_ACT: begin
            if (!m_db) begin
              m_state = M_DIS; m_entry = m_edge;
            end else if (m_hb) begin
              m_wd_ref = m_edge;
            end else if (m_edge - m_wd_ref >= WDOG + 1) begin
              m_state = M_FAULT; m_entry = m_edge;
            end
          end
          M_DIS: if (m_edge - m_entry == DRAIN) begin m_state = M_IDLE; m_entry = m_edge; end
          M_FAULT: if (!m_db) begin m_state = M_IDLE; m_entry = m_edge; end
          default: m_state = M_IDLE;
        endcase
        for (int i = DEB - 1; i > 0; i--) sync_h[i] = sync_h[i-1];
        sync_h[0] = sw_h[1];
        m_flip = 1'b1;
        for (int i = 0; i < DEB; i++) if (sync_h[i] == m_db) m_flip = 1'b0;
        if (m_flip) m_db = ~m_db;
        sw_h[1]  = sw_h[0];   sw_h[0]  = sw_req;
        tog_h[2] = tog_h[1];  tog_h[1] = tog_h[0];  tog_h[0] = aux_toggle;
      end
    end
  end

  function automatic logic [1:0] exp_led();
    case (m_state)
      M_EN:    return 2'd1;
      M_ACT:   return 2'd2;
      M_DIS:   return 2'd3;
      M_FAULT: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    check("model_sel",   {1'b0, sel_clk_aux}, {1'b0, m_state inside {M_EN, M_ACT, M_DIS}});
    check("model_ready", {1'b0, aux_ready},   {1'b0, m_state == M_ACT});
    check("model_fault", {1'b0, fault},       {1'b0, m_state == M_FAULT});
    check("model_led",   led_state,           exp_led());
    if (tog_period > 0) begin
      tog_cnt++;
      if (tog_cnt >= tog_period) begin
        aux_toggle = ~aux_toggle;
        tog_cnt = 0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},   {1'b0, sel_clk_aux}, 2'd0);
    check({tag, "_ready"}, {1'b0, aux_ready},   2'd0);
    check({tag, "_fault"}, {1'b0, fault},       2'd0);
    check({tag, "_led"},   led_state,           2'd0);
  endtask

  // Request high from the current negedge: sel after 19 edges, ready 8 later.
  task automatic enable_sequence(input string tag);
    sw_req = 1'b1;
    repeat (18) tick();
    check({tag, "_sel_pre"}, {1'b0, sel_clk_aux}, 2'd0);
    tick();
    check({tag, "_sel"}, {1'b0, sel_clk_aux}, 2'd1);
    check({tag, "_led_en"}, led_state, 2'd1);
    repeat (7) tick();
    check({tag, "_rdy_pre"}, {1'b0, aux_ready}, 2'd0);
    tick();
    check({tag, "_rdy"}, {1'b0, aux_ready}, 2'd1);
    check({tag, "_led_act"}, led_state, 2'd2);
  endtask

  initial begin
    int len;
    int gap;

    // Reset
    tick();
    tick();
    check_all_zero("reset");
    NRST = 1'b1;

    // Enable with a running heartbeat
    tog_period = 10;
    enable_sequence("en1");
    repeat (30) tick();
    check("active_fault", {1'b0, fault}, 2'd0);

    // Watchdog: one last toggle, then frozen
    tog_period = 0;
    tick();
    aux_toggle = ~aux_toggle;
    repeat (67) tick();
    check("wd_pre_fault", {1'b0, fault}, 2'd0);
    tick();
    check("wd_fault", {1'b0, fault}, 2'd1);
    check("wd_sel", {1'b0, sel_clk_aux}, 2'd0);
    check("wd_ready", {1'b0, aux_ready}, 2'd0);
    check("wd_led", led_state, 2'd3);
    sw_req = 1'b0;
    repeat (18) tick();
    check("fault_hold", {1'b0, fault}, 2'd1);
    tick();
    check("fault_clear", {1'b0, fault}, 2'd0);
    check("fault_led", led_state, 2'd0);
    repeat (10) tick();

    // Bounce rejection
    sw_req = 1'b1;
    for (int i = 0; i < 55; i++) begin
      if (i == 10) sw_req = 1'b0;
      if (i == 13) sw_req = 1'b1;
      if (i == 25) sw_req = 1'b0;
      tick();
      check("bounce_sel", {1'b0, sel_clk_aux}, 2'd0);
      check("bounce_led", led_state, 2'd0);
    end

    // Orderly release
    tog_period = 10;
    enable_sequence("en2");
    repeat (10) tick();
    sw_req = 1'b0;
    repeat (18) tick();
    check("rel_rdy_pre", {1'b0, aux_ready}, 2'd1);
    tick();
    check("rel_rdy", {1'b0, aux_ready}, 2'd0);
    check("rel_sel_drain", {1'b0, sel_clk_aux}, 2'd1);
    check("rel_led_dis", led_state, 2'd3);
    repeat (3) tick();
    check("rel_sel_pre", {1'b0, sel_clk_aux}, 2'd1);
    tick();
    check("rel_sel", {1'b0, sel_clk_aux}, 2'd0);
    check("rel_led", led_state, 2'd0);
    repeat (10) tick();

    // Abort during ENABLING (long-settle instance)
    sw_req = 1'b1;
    repeat (19) tick();
    check("abort_led_en", led_b, 2'd1);
    sw_req = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      tick();
      check("abort_ready", {1'b0, ready_b}, 2'd0);
      if (i == 18) check("abort_led_pre", led_b, 2'd1);
      if (i == 19) check("abort_led_dis", led_b, 2'd3);
      if (i == 22) check("abort_sel_drain", {1'b0, sel_b}, 2'd1);
      if (i == 23) check("abort_led_idle", led_b, 2'd0);
    end
    repeat (10) tick();

    // Race: debounced release lands on the watchdog expiry edge
    sw_req = 1'b1;
    repeat (40) tick();
    tog_period = 0;
    tick();
    aux_toggle = ~aux_toggle;
    repeat (49) tick();
    sw_req = 1'b0;
    repeat (18) tick();
    check("race_led_pre", led_state, 2'd2);
    tick();
    check("race_led", led_state, 2'd3);
    check("race_fault", {1'b0, fault}, 2'd0);
    check("race_sel", {1'b0, sel_clk_aux}, 2'd1);
    repeat (10) tick();

    // Reset during ACTIVE, then during DISABLING
    tog_period = 10;
    sw_req = 1'b1;
    repeat (40) tick();
    #2 NRST = 1'b0;
    #1 check_all_zero("rst_act");
    tick();
    NRST = 1'b1;
    enable_sequence("en3");
    sw_req = 1'b0;
    repeat (20) tick();
    check("rst_dis_led", led_state, 2'd3);
    #2 NRST = 1'b0;
    #1 check_all_zero("rst_dis");
    sw_req = 1'b1;
    tick();
    NRST = 1'b1;
    enable_sequence("en4");

    // Randomized traffic
    tog_period = 0;
    for (int s = 0; s < 60; s++) begin
      sw_req = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 100);
      case ($urandom_range(0, 2))
        0:       gap = 4;
        1:       gap = 15;
        default: gap = 150;
      endcase
      repeat (len) begin
        tick();
        if ($urandom_range(0, gap - 1) == 0) aux_toggle = ~aux_toggle;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
